// File: rtl/fsm_run_sequencer.sv
// fsm_run_sequencer
// Sequences one run of an attached state-machine block. While idle the FSM is
// held in reset. A start request opens a fixed reset window, then releases the
// FSM for a programmed number of cycles, and then reasserts reset. During the
// released window the sequencer counts how often state_out is high and how
// often it changes. A one-cycle done pulse reports the end of every run,
// whether the run completed or was aborted.
module fsm_run_sequencer #(
    parameter int CNT_W      = 16,
    parameter int RST_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,        // asynchronous, active low
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] run_cycles,
    input  logic             state_out,
    output logic             fsm_reset,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] toggle_count,
    output logic [CNT_W-1:0] high_count
);

    // The phase counter times both the reset window and the run window, so it
    // must be wide enough for whichever of the two is longer.
    localparam int RST_W = $clog2(RST_CYCLES + 1);
    localparam int PH_W  = (CNT_W > RST_W) ? CNT_W : RST_W;

    localparam logic [PH_W-1:0] RST_LOAD = PH_W'(RST_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RST_HOLD,
        RUN,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  run_len;
    logic [PH_W-1:0]   phase;
    logic              prev_state;
    logic              phase_last;

    // The phase counter counts down, so a window ends when it reaches zero.
    assign phase_last = (phase == '0);

    // The FSM runs only in RUN. The outputs are decoded straight from the state
    // register, so they change on the same edge as the state itself.
    assign fsm_reset = (state != RUN);
    assign busy      = (state == RST_HOLD) || (state == RUN);
    assign done      = (state == DONE);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments, so that every
        // register in the design samples its inputs from before the edge.
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: an abort is honoured only while a run is active, and a
    // start is honoured only in IDLE.
    always_comb begin
        // NOTE: the default comes first, so any path that does not assign
        // state_nxt holds the state and no latch is inferred.
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RST_HOLD;
                end
            end
            RST_HOLD: begin
                if (abort) begin
                    state_nxt = DONE;
                end else if (phase_last) begin
                    state_nxt = (run_len != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (abort || phase_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Run bookkeeping: latch the run length, time the windows, gather statistics
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_len      <= '0;
            phase        <= '0;
            prev_state   <= 1'b0;
            aborted      <= 1'b0;
            toggle_count <= '0;
            high_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        run_len      <= run_cycles;
                        phase        <= RST_LOAD;
                        aborted      <= 1'b0;
                        toggle_count <= '0;
                        high_count   <= '0;
                    end
                end
                RST_HOLD: begin
                    // Track state_out during the reset window, so that the first
                    // RUN cycle compares against what the FSM showed in reset.
                    prev_state <= state_out;
                    if (abort) begin
                        aborted <= 1'b1;
                    end else if (phase_last) begin
                        // When run_len is zero this wraps, which is harmless,
                        // because the next state is DONE.
                        phase <= PH_W'(run_len) - PH_W'(1);
                    end else begin
                        phase <= phase - PH_W'(1);
                    end
                end
                RUN: begin
                    // The cycle in which abort is sampled still counts.
                    high_count <= high_count + CNT_W'(state_out);
                    if (state_out != prev_state) begin
                        toggle_count <= toggle_count + CNT_W'(1);
                    end
                    prev_state <= state_out;
                    phase      <= phase - PH_W'(1);
                    if (abort) begin
                        aborted <= 1'b1;
                    end
                end
                default: begin
                    // DONE: the results hold until the next accepted start.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_run_sequencer.sv
// tb_fsm_run_sequencer
// Self-checking bench for fsm_run_sequencer. The reference model works on a
// timeline. An accepted start at edge k opens the reset window over the outputs
// after edges k..k+R-1. The run window covers the outputs up to, but not
// including, the done edge k+R+L. An abort sampled at edge e moves the done edge
// to e. The statistics accumulate at the edges that fall inside the run window.
module tb_fsm_run_sequencer;

    localparam int CNT_W = 16;
    localparam int R     = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] run_cycles;
    logic             state_out;
    logic             fsm_reset;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [CNT_W-1:0] toggle_count;
    logic [CNT_W-1:0] high_count;

    fsm_run_sequencer #(.CNT_W(CNT_W), .RST_CYCLES(R)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .run_cycles   (run_cycles),
        .state_out    (state_out),
        .fsm_reset    (fsm_reset),
        .busy         (busy),
        .done         (done),
        .aborted      (aborted),
        .toggle_count (toggle_count),
        .high_count   (high_count)
    );

    always #10 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- timeline reference model ----------------
    typedef enum int {P_IDLE, P_HOLD, P_RUN, P_DONE} phase_e;

    int cyc         = 0;   // number of rising edges seen so far
    bit m_active    = 0;   // at least one run has started since the last reset
    int m_k         = 0;   // edge at which the current run was accepted
    int m_done_edge = 0;   // edge after which done must be high
    bit m_aborted   = 0;
    int m_high      = 0;
    int m_tog       = 0;
    bit m_prev      = 0;

    // Phase expected in the outputs after edge n
    function automatic phase_e phase_at(input int n);
        if (!m_active)        return P_IDLE;
        if (n < m_done_edge)  return (n - m_k < R) ? P_HOLD : P_RUN;
        if (n == m_done_edge) return P_DONE;
        return P_IDLE;
    endfunction

    task automatic model_reset();
        m_active  = 0;
        m_aborted = 0;
        m_high    = 0;
        m_tog     = 0;
        m_prev    = 0;
    endtask

    task automatic compare();
        phase_e e;
        e = phase_at(cyc);
        check("fsm_reset", 32'(fsm_reset), 32'(e != P_RUN));
        check("busy", 32'(busy), 32'(e == P_HOLD || e == P_RUN));
        check("done", 32'(done), 32'(e == P_DONE));
        check("aborted", 32'(aborted), 32'(m_aborted));
        check("toggle_count", 32'(toggle_count), 32'(m_tog));
        check("high_count", 32'(high_count), 32'(m_high));
    endtask

    // One clock: advance the model with the inputs the edge sampled, then compare.
    task automatic cycle();
        phase_e p;
        @(posedge clk);
        p = phase_at(cyc);
        cyc++;
        if (reset) begin
            if (p == P_HOLD || p == P_RUN) begin
                if (p == P_RUN) begin
                    m_high += int'(state_out);
                    if (state_out != m_prev) m_tog++;
                end
                m_prev = state_out;
                if (abort) begin
                    m_done_edge = cyc;
                    m_aborted   = 1;
                end
            end else if (p == P_IDLE && start) begin
                m_active    = 1;
                m_k         = cyc;
                m_done_edge = cyc + R + int'(run_cycles);
                m_high      = 0;
                m_tog       = 0;
                m_aborted   = 0;
            end
        end
        #1;
        compare();
    endtask

    // Assert reset between edges and check that it takes effect at once.
    task automatic async_reset();
        #4;
        reset = 1'b0;
        model_reset();
        #1;
        compare();
    endtask

    // Runs one sequence from IDLE back to IDLE.
    // mode 0: state_out alternates 1,0,1,... in RUN; mode 1: held at 1 in RUN;
    // mode 2: random state_out, start and abort on every cycle.
    // abort_at: abort asserted in this RUN cycle (0 = never).
    // poke: pulse start in RUN cycle 3 and in the DONE cycle.
    task automatic run(input int len, input int mode, input int abort_at, input bit poke,
                       output int done_off, output int n_hold, output int n_run);
        int guard   = 0;
        int run_idx = 0;
        int k;
        bit alt     = 1'b1;
        done_off = -1;
        n_hold   = 0;
        n_run    = 0;
        run_cycles = CNT_W'(len);
        start      = 1'b1;
        abort      = (mode == 2) ? 1'($urandom) : 1'b0;   // a start in IDLE beats an abort
        state_out  = 1'b0;
        cycle();
        k = cyc;
        run_cycles = CNT_W'(len + 3);                     // later starts must not relatch this
        while (guard < 400) begin
            if (done) done_off = cyc - k;
            if (busy && fsm_reset) n_hold++;
            if (!fsm_reset) n_run++;
            if (!busy && !done) break;
            start = 1'b0;
            abort = 1'b0;
            if (!fsm_reset) begin
                run_idx++;
                state_out = (mode == 0) ? alt : (mode == 1) ? 1'b1 : 1'($urandom);
                alt = ~alt;
                if (run_idx == abort_at) abort = 1'b1;
                if (poke && run_idx == 3) start = 1'b1;
            end else begin
                state_out = (mode == 2) ? 1'($urandom) : 1'b0;
            end
            if (poke && done) start = 1'b1;
            if (mode == 2) begin
                if ($urandom_range(0, 15) == 0) abort = 1'b1;
                if ($urandom_range(0, 7) == 0) start = 1'b1;
            end
            cycle();
            guard++;
        end
        if (guard >= 400) begin
            n_tests++;
            n_fail++;
            $display("FAIL run_timeout: still busy after %0d cycles, expected idle", guard);
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        int d_off, n_h, n_r;

        // Reset held for 3 cycles with start high: no run may begin.
        reset      = 1'b0;
        start      = 1'b1;
        abort      = 1'b0;
        state_out  = 1'b0;
        run_cycles = CNT_W'(10);
        model_reset();
        #1;
        compare();
        repeat (3) cycle();
        check("rst_fsm_reset", 32'(fsm_reset), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        start = 1'b0;
        #4;
        reset = 1'b1;
        cycle();
        cycle();

        // Normal run: 10 cycles, alternating state_out
        run(10, 0, 0, 1'b0, d_off, n_h, n_r);
        check("norm_done_off", 32'(d_off), 32'd12);
        check("norm_hold_cycles", 32'(n_h), 32'd2);
        check("norm_run_cycles", 32'(n_r), 32'd10);
        check("norm_toggle", 32'(toggle_count), 32'd10);
        check("norm_high", 32'(high_count), 32'd5);
        check("norm_aborted", 32'(aborted), 32'd0);
        cycle();

        // Zero-length run
        run(0, 0, 0, 1'b0, d_off, n_h, n_r);
        check("zero_done_off", 32'(d_off), 32'd2);
        check("zero_run_cycles", 32'(n_r), 32'd0);
        check("zero_toggle", 32'(toggle_count), 32'd0);
        check("zero_high", 32'(high_count), 32'd0);

        // Abort in the 4th RUN cycle, with state_out held at 1
        run(10, 1, 4, 1'b0, d_off, n_h, n_r);
        check("abort_done_off", 32'(d_off), 32'd6);
        check("abort_high", 32'(high_count), 32'd4);
        check("abort_toggle", 32'(toggle_count), 32'd1);
        check("abort_flag", 32'(aborted), 32'd1);
        cycle();
        run(2, 0, 0, 1'b0, d_off, n_h, n_r);
        check("abort_cleared", 32'(aborted), 32'd0);

        // Starts ignored mid-RUN and in the DONE cycle
        run(10, 0, 0, 1'b1, d_off, n_h, n_r);
        check("poke_done_off", 32'(d_off), 32'd12);
        check("poke_idle_busy", 32'(busy), 32'd0);
        cycle();
        check("poke_still_idle", 32'(busy), 32'd0);

        // Reset asserted in RUN cycle 5
        run_cycles = CNT_W'(10);
        start      = 1'b1;
        cycle();
        start = 1'b0;
        repeat (R + 4) begin
            state_out = ~fsm_reset;
            cycle();
        end
        check("midrst_in_run", 32'(fsm_reset), 32'd0);
        async_reset();
        check("midrst_fsm_reset", 32'(fsm_reset), 32'd1);
        check("midrst_high", 32'(high_count), 32'd0);
        check("midrst_toggle", 32'(toggle_count), 32'd0);
        repeat (2) cycle();
        check("midrst_no_done", 32'(done), 32'd0);
        #4;
        reset = 1'b1;
        cycle();
        run(3, 0, 0, 1'b0, d_off, n_h, n_r);
        check("after_rst_done_off", 32'(d_off), 32'd5);
        check("after_rst_high", 32'(high_count), 32'd2);

        // Randomised runs
        for (int i = 0; i < 40; i++) begin
            run($urandom_range(0, 20), 2, 0, 1'b0, d_off, n_h, n_r);
            repeat ($urandom_range(0, 3)) cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fsm_run_sequencer.md
Name: fsm_run_sequencer

Overview:
- Controller that sequences a run of the state-machine block (clk/reset/state_out interface).
- Holds the FSM in reset while idle. On a start request it applies a timed reset window, releases the FSM for a programmed number of cycles, then reasserts reset.
- During the run it gathers activity statistics on state_out and reports them with a done pulse.
- Sits between a test/control host and the FSM instance. It drives the FSM's reset pin and observes its state_out.

Parameters:
- CNT_W, 16, width of run_cycles and of both statistic counters.
- RST_CYCLES, 2, number of cycles fsm_reset is held before release. Legal range is >= 1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  run request; sampled in IDLE only.
- abort  input  1  terminate the current run early; sampled in RST_HOLD and RUN.
- run_cycles  input  CNT_W  run length in cycles; latched on an accepted start.
- state_out  input  1  FSM output under observation; same clock domain.
- fsm_reset  output  1  active-high reset to the FSM.
- busy  output  1  high in RST_HOLD and RUN.
- done  output  1  one-cycle pulse in the DONE state.
- aborted  output  1  high when the last run ended through abort; held until the next accepted start.
- toggle_count  output  CNT_W  number of state_out transitions during RUN.
- high_count  output  CNT_W  number of RUN cycles with state_out = 1.

Behaviour:
- Reset (reset = 0, asynchronous) forces:
  - state to IDLE;
  - busy = 0, done = 0, aborted = 0;
  - toggle_count = 0, high_count = 0;
  - run_len = 0, phase counter = 0, prev_state = 0.
  - fsm_reset reads 1 throughout reset.
- Reset mid-operation abandons the run immediately; no done pulse is produced.
- fsm_reset = (state != RUN), decoded directly from the state register with no extra delay.
- States: IDLE, RST_HOLD, RUN, DONE.
- IDLE:
  - On start = 1: latch run_cycles into run_len, clear both counts, clear aborted, load phase counter, go to RST_HOLD.
  - start = 0: stay in IDLE.
- RST_HOLD:
  - Lasts exactly RST_CYCLES cycles.
  - prev_state <= state_out every cycle.
  - Then go to RUN if run_len != 0, otherwise go to DONE.
- RUN:
  - Lasts exactly run_len cycles.
  - Each cycle: high_count += state_out; toggle_count += (state_out != prev_state); prev_state <= state_out.
  - Counts cannot exceed run_len, so no saturation is needed.
  - After the last cycle, go to DONE.
- DONE:
  - Lasts exactly one cycle, with done = 1; then go to IDLE.
  - toggle_count, high_count and aborted hold their values until the next accepted start.
- Abort:
  - abort = 1 in RST_HOLD or RUN: the next state is DONE and aborted <= 1.
  - Counts keep every RUN cycle completed, including the cycle in which abort was sampled.
  - abort is ignored in IDLE and DONE.
- Start is ignored in RST_HOLD, RUN and DONE.
  - No queuing: a start asserted in the DONE cycle is lost.
- Simultaneous start and abort in IDLE: start wins and abort is ignored.
- Latency: with start accepted at edge k, done is high in the cycle following edge k + RST_CYCLES + run_len.

Test Plan:
- Reset: hold reset = 0 for 3 cycles (20 ns clock) with start = 1 -> busy = 0, done = 0, fsm_reset = 1, counts = 0, and no run starts.
- Normal run (RST_CYCLES = 2, run_cycles = 10): state_out = 0 during RST_HOLD, then alternating 1,0,1,... in RUN.
  - fsm_reset is high for exactly 2 cycles after start, then low for exactly 10 cycles.
  - done pulses 12 cycles after the start edge.
  - toggle_count = 10, high_count = 5, aborted = 0.
- Zero length (run_cycles = 0): fsm_reset never drops; done pulses 2 cycles after start; counts = 0.
- Abort: run_cycles = 10 with state_out held at 1; assert abort in the 4th RUN cycle.
  - DONE follows in the next cycle.
  - high_count = 4, toggle_count = 1, aborted = 1.
  - The next accepted start clears aborted.
- Ignored start: pulse start mid-RUN and again in the DONE cycle -> the run length is unchanged and the sequencer returns to IDLE with busy = 0.
- Reset mid-RUN: drive reset = 0 in RUN cycle 5.
  - IDLE, fsm_reset = 1 and counts = 0 take effect immediately.
  - No done pulse occurs.
  - After release, a new start with run_cycles = 3 completes normally.
